// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Data-memory responder sitting behind the MEM-stage access interface.
// Loads are answered one cycle after acceptance; stores are posted into a
// small in-order store buffer and later drained into a single-port word RAM
// whenever no load is using the port. Loads merge any newer bytes still held
// in the buffer so the returned data is always architecturally current.
//
// Parameters
//   ADDR_W    word-address width; RAM holds 2^ADDR_W 32-bit words
//   SB_DEPTH  store-buffer entries (power of two, >= 2)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   req_valid   request present this cycle
//   req_we      1 = store, 0 = load
//   req_addr    byte address; word index = req_addr[ADDR_W+1:2]
//   req_be      byte-lane enables (bit i -> bits [8i+7:8i])
//   req_wdata   lane-aligned store data
//   req_ready   request accepted when req_valid && req_ready
//   resp_valid  load data valid (one cycle after load acceptance)
//   resp_rdata  load data; lanes outside the load's be are 0
//   sb_empty    store buffer holds no entries
//   sb_full     store buffer holds SB_DEPTH entries
// -----------------------------------------------------------------------------
module dm_responder #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        sb_empty,
  output logic        sb_full
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0]       r_mem     [WORDS];
  logic [ADDR_W-1:0] r_sb_idx  [SB_DEPTH];
  logic [3:0]        r_sb_be   [SB_DEPTH];
  logic [31:0]       r_sb_data [SB_DEPTH];

  // Buffer control
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  // Load response stage
  logic              r_vld_p1;
  logic [31:0]       r_ram_q_p1;
  logic [3:0]        r_fwd_mask_p1;
  logic [31:0]       r_fwd_data_p1;
  logic [3:0]        r_ld_be_p1;

  // Request decode
  logic [ADDR_W-1:0] w_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_ld_acc;
  logic              w_st_acc;
  logic              w_drain;
  logic [3:0]        w_fwd_mask;
  logic [31:0]       w_fwd_data;
  logic [PTR_W-1:0]  w_slot;
  logic              w_unused_addr;

  assign w_idx         = req_addr[ADDR_W+1:2];
  assign w_unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign sb_empty  = w_empty;
  assign sb_full   = w_full;

  // Full test uses the registered count: a drain in the same cycle does not
  // open a slot for a same-cycle store.
  assign req_ready = !(req_we && w_full);

  assign w_ld_acc  = req_valid && !req_we;
  assign w_st_acc  = req_valid && req_we && !w_full;

  // A load owns the RAM port; any other cycle with buffered data drains the
  // head entry. A store never touches the RAM port, so a store cycle drains
  // alongside the buffer write.
  assign w_drain   = !w_ld_acc && !w_empty;

  // ---------------------------------------------------------------------------
  // Stage 0: store-to-load forwarding
  // Walk valid entries oldest to youngest so the youngest write of each lane
  // ends up in the forward data.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fwd_mask = '0;
    w_fwd_data = '0;
    w_slot     = r_head;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_slot = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_sb_idx[w_slot] == w_idx)) begin
        for (int l = 0; l < 4; l++) begin
          if (r_sb_be[w_slot][l]) begin
            w_fwd_mask[l]         = 1'b1;
            w_fwd_data[8*l +: 8]  = r_sb_data[w_slot][8*l +: 8];
          end
        end
      end
    end
  end

  // Buffer pointers, occupancy and response valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      if (w_st_acc) r_tail <= r_tail + 1'b1;
      if (w_drain)  r_head <= r_head + 1'b1;
      case ({w_st_acc, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_vld_p1 <= w_ld_acc;
    end
  end

  // Buffer entry write and load-side capture of the forward result.
  always_ff @(posedge clk) begin
    if (w_st_acc) begin
      r_sb_idx[r_tail]  <= w_idx;
      r_sb_be[r_tail]   <= req_be;
      r_sb_data[r_tail] <= req_wdata;
    end
    if (w_ld_acc) begin
      r_fwd_mask_p1 <= w_fwd_mask;
      r_fwd_data_p1 <= w_fwd_data;
      r_ld_be_p1    <= req_be;
    end
  end

  // Single-port RAM: either a load read or a head-entry drain write.
  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      r_ram_q_p1 <= r_mem[w_idx];
    end else if (w_drain) begin
      for (int l = 0; l < 4; l++) begin
        if (r_sb_be[r_head][l]) begin
          r_mem[r_sb_idx[r_head]][8*l +: 8] <= r_sb_data[r_head][8*l +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: response merge
  // Forwarded bytes override RAM bytes; lanes the load did not enable are 0,
  // and the whole word is 0 outside a response cycle.
  // ---------------------------------------------------------------------------
  assign resp_valid = r_vld_p1;

  always_comb begin
    resp_rdata = '0;
    for (int l = 0; l < 4; l++) begin
      if (r_vld_p1 && r_ld_be_p1[l]) begin
        resp_rdata[8*l +: 8] = r_fwd_mask_p1[l] ? r_fwd_data_p1[8*l +: 8]
                                                : r_ram_q_p1[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//
// Bench for dm_responder. A behavioural model holds memory as a byte map and
// the store buffer as a queue of pending stores; a compare process checks
// every output on each falling edge against it, and the directed sequence
// pins the model with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_dm_responder;

  localparam int ADDR_W   = 10;
  localparam int SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        sb_empty;
  logic        sb_full;

  int checks = 0;
  int errors = 0;

  dm_responder #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .sb_empty   (sb_empty),
    .sb_full    (sb_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          idx;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [7:0]  m_mem[int];
  bit          m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_cmask = '0;
  bit          m_ld, m_st, m_got;
  int          m_w;
  logic [7:0]  m_b;
  ent_t        m_e;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 32'd1));
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      m_rv = 1'b0;
      if (rst) begin
        m_q.delete();
      end else begin
        m_ld = req_valid && !req_we;
        m_st = req_valid && req_we && (m_q.size() < SB_DEPTH);
        m_w  = widx(req_addr);
        if (m_ld) begin
          m_rv    = 1'b1;
          m_rd    = '0;
          m_cmask = 32'hFFFF_FFFF;
          for (int l = 0; l < 4; l++) begin
            if (req_be[l]) begin
              m_got = 1'b0;
              m_b   = 8'h00;
              foreach (m_q[e]) begin
                if (m_q[e].idx == m_w && m_q[e].be[l]) begin
                  m_got = 1'b1;
                  m_b   = m_q[e].data[8*l +: 8];
                end
              end
              if (!m_got) begin
                if (m_mem.exists(m_w*4 + l)) m_b = m_mem[m_w*4 + l];
                else m_cmask[8*l +: 8] = 8'h00;
              end
              m_rd[8*l +: 8] = m_b;
            end
          end
        end else if (m_q.size() > 0) begin
          m_e = m_q.pop_front();
          for (int l = 0; l < 4; l++)
            if (m_e.be[l]) m_mem[m_e.idx*4 + l] = m_e.data[8*l +: 8];
        end
        if (m_st) m_q.push_back('{m_w, req_be, req_wdata});
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("resp_valid", 32'(resp_valid), 32'(m_rv));
    if (m_rv) check("resp_rdata", resp_rdata & m_cmask, m_rd & m_cmask);
    check("sb_empty", 32'(sb_empty), 32'(m_q.size() == 0));
    check("sb_full", 32'(sb_full), 32'(m_q.size() == SB_DEPTH));
    check("req_ready", 32'(req_ready), 32'(!(req_we && m_q.size() == SB_DEPTH)));
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    req_wdata = $urandom;
  endtask

  task automatic idle_cyc();
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic [31:0] a, input logic [3:0] be);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_be = be; req_wdata = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_be = be; req_wdata = d;
      #1;
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    check("store_accept", 32'(acc), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_sb_empty",   32'(sb_empty),   32'd1);
    check("rst_sb_full",    32'(sb_full),    32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    @(posedge clk); #1;

    // Store, drain in an idle cycle, load back.
    st(32'h10, 4'b1111, 32'hDEAD_BEEF);
    idle_cyc();
    ld(32'h10, 4'b1111);
    check("drain_valid",    32'(resp_valid), 32'd1);
    check("drain_rdata",    resp_rdata,      32'hDEAD_BEEF);
    check("drain_sb_empty", 32'(sb_empty),   32'd1);

    // Forward a buffered byte over the RAM word.
    st(32'h20, 4'b1111, 32'h1122_3344);
    idle_cyc();
    st(32'h20, 4'b0010, 32'h0000_AA00);
    ld(32'h20, 4'b1111);
    check("fwd_rdata",    resp_rdata,    32'h1122_AA44);
    check("fwd_sb_empty", 32'(sb_empty), 32'd0);

    // Partial-lane load.
    idle_cyc();
    ld(32'h20, 4'b1100);
    check("partial_rdata", resp_rdata, 32'h1122_0000);

    // Stores under continuous load pressure; pointers wrap several times.
    for (int i = 0; i < 6; i++) begin
      st(32'h80 + 32'(4*i), 4'b1111, 32'(i+1) * 32'h1111_1111);
      ld(32'h80 + 32'(4*i), 4'b1111);
      check("press_fwd", resp_rdata, 32'(i+1) * 32'h1111_1111);
      ld(32'h80 + 32'(4*i), 4'b1111);
      check("press_fwd2", resp_rdata, 32'(i+1) * 32'h1111_1111);
    end
    st(32'h80, 4'b0001, 32'h0000_00FF);
    ld(32'h80, 4'b1111);
    check("press_merge", resp_rdata, 32'h1111_11FF);
    st(32'h84, 4'b0000, 32'hFFFF_FFFF);
    repeat (3) idle_cyc();
    check("press_drained", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 6; i++) begin
      ld(32'h80 + 32'(4*i), 4'b1111);
      check("final_ram", resp_rdata, (i == 0) ? 32'h1111_11FF : 32'(i+1) * 32'h1111_1111);
    end

    // Reset with a buffered store and an in-flight response.
    st(32'h10, 4'b1111, 32'hCAFE_F00D);
    ld(32'h20, 4'b1111);
    check("pre_rst_valid", 32'(resp_valid), 32'd1);
    check("pre_rst_empty", 32'(sb_empty),   32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_empty", 32'(sb_empty),   32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ld(32'h10, 4'b1111);
    check("post_rst_rdata", resp_rdata, 32'hDEAD_BEEF);
    idle_cyc();
    idle_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
